occupancy_map_arbiter: RTL and testbench
========================================

# occupancy_map_arbiter

Sequences and shares the single-port occupancy map RAM (256 × 128 log-odds cells) among three clients: the map-update stage (read-modify-write), the scan matcher (reads), and an optional debug dump reader. It also runs a full-map clear sequence on command. It sits between the dataflow stages and the RAM instance inside the occupancy module, and is the only driver of the RAM port.

## Interface
- DATA_WIDTH, 8: log-odds cell width, signed two's complement
- LOG_ODDS_MIN, -127: lower saturation bound for updates
- LOG_ODDS_MAX, 127: upper saturation bound for updates
- CLEAR_VALUE, 0: value written to every cell by a clear
- STARVE_LIMIT, 4: consecutive update grants allowed while the matcher waits
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- clear_start  in  1  one-cycle pulse requesting a full-map clear
- clear_done  out  1  one-cycle pulse after the last clear write
- busy  out  1  high while clearing or while an update is in flight
- upd_valid / upd_ready  in / out  1 / 1  update request handshake
- upd_addr  in  15  cell address {y[6:0], x[7:0]}
- upd_delta  in  DATA_WIDTH  signed increment
- mat_valid / mat_ready  in / out  1 / 1  matcher read request handshake
- mat_addr  in  15  matcher read address
- mat_rsp_valid / mat_rsp_data  out  1 / DATA_WIDTH  matcher read response
- dump_valid / dump_ready / dump_addr / dump_rsp_valid / dump_rsp_data: same as the matcher ports (compiled in only with the macro)
- mem_addr / mem_we / mem_wdata  out  15 / 1 / DATA_WIDTH  RAM port
- mem_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after the address

## Operation
- States: IDLE, UPD_WR, CLEAR.
- Reset (reset=0): state goes to IDLE. Every output is 0: all readies, all rsp_valid and rsp_data, clear_done, busy, mem_addr, mem_we, mem_wdata. The starvation counter and clear counter are 0. A clear in progress is abandoned and no further writes are issued.
- IDLE grant priority:
  - clear_start has the highest priority.
  - update is next, except when the starvation counter equals STARVE_LIMIT and mat_valid=1. In that case the matcher wins.
  - matcher is next, then dump.
  - Exactly one ready is high per cycle, and only toward a requester whose valid is high. Ready is combinational from the valids and the state.
- Update: on acceptance, drive mem_addr=upd_addr with mem_we=0, and go to UPD_WR.
  - In UPD_WR: mem_we=1, same address, mem_wdata=clamp(mem_rdata + upd_delta).
  - The sum is formed at DATA_WIDTH+1 bits signed and clamped to [LOG_ODDS_MIN, LOG_ODDS_MAX].
  - Address and delta are registered at acceptance. Return to IDLE.
- Reads: on acceptance, drive mem_addr with mem_we=0. The matching rsp_valid is high the next cycle, with rsp_data=mem_rdata. Back-to-back reads are accepted every cycle.
- Starvation counter:
  - Increments on each update grant while mat_valid=1.
  - Clears on each matcher grant, or when mat_valid=0.
- Clear: clear_start in IDLE goes to CLEAR. Write CLEAR_VALUE to addresses 0..32767, one per cycle. After address 32767, pulse clear_done and return to IDLE. All readies are 0 during CLEAR. clear_start is ignored outside IDLE.

## Timing
- Read latency: 1 cycle from acceptance to rsp_valid.
- Update occupancy: 2 cycles; no grant is given in the UPD_WR cycle.
- A read accepted the cycle after UPD_WR returns the updated value.
- Clear: 32768 write cycles; clear_done is high in the cycle after the final write; busy is high from the cycle after clear_start through the final write.
- If clear_start and upd_valid are high in the same cycle, clear wins and upd_ready=0.

## Configuration
- OCC_ARB_DUMP_PORT_EN defined: the dump ports exist, with lowest priority.
- OCC_ARB_DUMP_PORT_EN undefined: the dump ports are absent, and the arbiter serves only clear, update and matcher.

## Structure
- Package occupancy_map_pkg holds:
  - MAP_WIDTH=256, MAP_HEIGHT=128, ADDR_WIDTH=15
  - map_addr_t, log_odds_t
  - arb_state_t enum {IDLE, UPD_WR, CLEAR}
- One sub-module, log_odds_saturating_adder: combinational widened add plus clamp, parameterised by width and bounds.

## Test plan
- Update with preset cell 100 at addr 0x0105, delta +50: write of 127 at 0x0105 in the cycle after acceptance. A later matcher read returns 127.
- Update with cell -120, delta -20: writes -127.
- upd_valid and mat_valid both held high: the pattern is 4 update grants, then 1 matcher grant, repeating. The matcher is never blocked for more than 9 cycles.
- Matcher reads on 3 consecutive cycles at 0, 1, 2: rsp_valid for 3 consecutive cycles, each one cycle later, data in order.
- clear_start plus concurrent upd_valid: no upd_ready for 32768 cycles, and every address reads 0 afterward. clear_done pulses exactly once.
- reset=0 at write 1000 of a clear: outputs go to 0 next cycle, no further writes, and the state is IDLE with clear_done never pulsed.

Source files
------------

// File: rtl/occupancy_map_pkg.sv
// ---------------------------------------------------------------------------
// occupancy_map_pkg
// Shared geometry, types and arbiter state encoding for the occupancy map
// RAM arbiter. The map is 256 (x) by 128 (y) signed log-odds cells, addressed
// as {y[6:0], x[7:0]}.
// ---------------------------------------------------------------------------
package occupancy_map_pkg;

    localparam int MAP_WIDTH      = 256;
    localparam int MAP_HEIGHT     = 128;
    localparam int ADDR_WIDTH     = 15;
    localparam int LOG_ODDS_WIDTH = 8;

    typedef logic        [ADDR_WIDTH-1:0]     map_addr_t;
    typedef logic signed [LOG_ODDS_WIDTH-1:0] log_odds_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPD_WR = 2'd1,
        CLEAR  = 2'd2
    } arb_state_t;

    // Highest cell address; a clear sweep ends after writing this one.
    localparam map_addr_t LAST_ADDR = map_addr_t'(MAP_WIDTH * MAP_HEIGHT - 1);

endpackage

// File: rtl/log_odds_saturating_adder.sv
// ---------------------------------------------------------------------------
// log_odds_saturating_adder
// Combinational signed add of two WIDTH-bit values, formed one bit wider so
// the raw sum cannot overflow, then clamped to [MIN_VAL, MAX_VAL].
//   i_a    in  WIDTH  current cell value (signed)
//   i_b    in  WIDTH  increment (signed)
//   o_sum  out WIDTH  clamped result (signed)
// ---------------------------------------------------------------------------
module log_odds_saturating_adder #(
    parameter int WIDTH   = 8,
    parameter int MIN_VAL = -127,
    parameter int MAX_VAL = 127
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_sum
);

    localparam logic signed [WIDTH:0] MIN_W = (WIDTH+1)'(MIN_VAL);
    localparam logic signed [WIDTH:0] MAX_W = (WIDTH+1)'(MAX_VAL);

    logic signed [WIDTH:0] w_wide_sum;

    assign w_wide_sum = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};

    // NOTE: every path assigns o_sum, so this stays purely combinational.
    always_comb begin
        if (w_wide_sum < MIN_W) begin
            o_sum = MIN_W[WIDTH-1:0];
        end else if (w_wide_sum > MAX_W) begin
            o_sum = MAX_W[WIDTH-1:0];
        end else begin
            o_sum = w_wide_sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/occupancy_map_arbiter.sv
// ---------------------------------------------------------------------------
// occupancy_map_arbiter
// Sole driver of the single-port occupancy map RAM. Shares it between the
// map-update stage (read-modify-write with saturation), the scan matcher
// (reads) and, when OCC_ARB_DUMP_PORT_EN is defined, a debug dump reader.
// Also runs a full-map clear sweep on command.
//
// Configuration macro: OCC_ARB_DUMP_PORT_EN (adds the dump ports, lowest
// priority). Without it only clear, update and matcher are served.
//
// Ports:
//   i_clock                      system clock, rising edge
//   i_reset                      synchronous, active-low reset
//   i_clear_start / o_clear_done clear request pulse / completion pulse
//   o_busy                       clearing or update write pending
//   i_upd_valid/o_upd_ready, i_upd_addr, i_upd_delta    update requests
//   i_mat_valid/o_mat_ready, i_mat_addr                 matcher reads
//   o_mat_rsp_valid, o_mat_rsp_data                     matcher responses
//   i_dump_* / o_dump_*          dump reader (macro only), as matcher
//   o_mem_addr, o_mem_we, o_mem_wdata, i_mem_rdata      RAM port
//                                (read data valid 1 cycle after address)
// ---------------------------------------------------------------------------
module occupancy_map_arbiter
    import occupancy_map_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int LOG_ODDS_MIN = -127,
    parameter int LOG_ODDS_MAX = 127,
    parameter int CLEAR_VALUE  = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_clear_start,
    output logic                  o_clear_done,
    output logic                  o_busy,
    input  logic                  i_upd_valid,
    output logic                  o_upd_ready,
    input  logic [ADDR_WIDTH-1:0] i_upd_addr,
    input  logic [DATA_WIDTH-1:0] i_upd_delta,
    input  logic                  i_mat_valid,
    output logic                  o_mat_ready,
    input  logic [ADDR_WIDTH-1:0] i_mat_addr,
    output logic                  o_mat_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_mat_rsp_data,
`ifdef OCC_ARB_DUMP_PORT_EN
    input  logic                  i_dump_valid,
    output logic                  o_dump_ready,
    input  logic [ADDR_WIDTH-1:0] i_dump_addr,
    output logic                  o_dump_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_dump_rsp_data,
`endif
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam int STARVE_W = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [DATA_WIDTH-1:0] CLEAR_WORD = DATA_WIDTH'(CLEAR_VALUE);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    map_addr_t             r_clr_cnt;
    map_addr_t             r_upd_addr;
    logic [DATA_WIDTH-1:0] r_upd_delta;
    logic [STARVE_W-1:0]   r_starve_cnt;
    logic                  r_clear_done;
    logic                  r_mat_rsp_valid;

    logic                  w_upd_ready;
    logic                  w_mat_ready;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_sat_sum;
    logic                  w_starved;

`ifdef OCC_ARB_DUMP_PORT_EN
    logic                  w_dump_ready;
    logic                  r_dump_rsp_valid;
`endif

    // Read-modify-write: i_mem_rdata holds the old cell value during UPD_WR.
    log_odds_saturating_adder #(
        .WIDTH   (DATA_WIDTH),
        .MIN_VAL (LOG_ODDS_MIN),
        .MAX_VAL (LOG_ODDS_MAX)
    ) u_sat_add (
        .i_a   (i_mem_rdata),
        .i_b   (r_upd_delta),
        .o_sum (w_sat_sum)
    );

    // The matcher pre-empts updates only once it has watched STARVE_LIMIT
    // consecutive update grants go by.
    assign w_starved = (r_starve_cnt == STARVE_MAX);

    always_comb begin
        w_next_state = r_state;
        w_upd_ready  = 1'b0;
        w_mat_ready  = 1'b0;
        w_mem_addr   = '0;
        w_mem_we     = 1'b0;
        w_mem_wdata  = '0;
`ifdef OCC_ARB_DUMP_PORT_EN
        w_dump_ready = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (i_clear_start) begin
                    w_next_state = CLEAR;
                end else if (w_starved && i_mat_valid) begin
                    w_mat_ready = 1'b1;
                    w_mem_addr  = i_mat_addr;
                end else if (i_upd_valid) begin
                    w_upd_ready  = 1'b1;
                    w_mem_addr   = i_upd_addr;
                    w_next_state = UPD_WR;
                end else if (i_mat_valid) begin
                    w_mat_ready = 1'b1;
                    w_mem_addr  = i_mat_addr;
                end
`ifdef OCC_ARB_DUMP_PORT_EN
                else if (i_dump_valid) begin
                    w_dump_ready = 1'b1;
                    w_mem_addr   = i_dump_addr;
                end
`endif
            end
            UPD_WR: begin
                w_mem_we     = 1'b1;
                w_mem_addr   = r_upd_addr;
                w_mem_wdata  = w_sat_sum;
                w_next_state = IDLE;
            end
            CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_cnt;
                w_mem_wdata = CLEAR_WORD;
                if (r_clr_cnt == LAST_ADDR) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase

        // Held in reset: nothing is granted and the RAM port is quiet.
        if (!i_reset) begin
            w_next_state = IDLE;
            w_upd_ready  = 1'b0;
            w_mat_ready  = 1'b0;
            w_mem_addr   = '0;
            w_mem_we     = 1'b0;
            w_mem_wdata  = '0;
`ifdef OCC_ARB_DUMP_PORT_EN
            w_dump_ready = 1'b0;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state         <= IDLE;
            r_clr_cnt       <= '0;
            r_upd_addr      <= '0;
            r_upd_delta     <= '0;
            r_starve_cnt    <= '0;
            r_clear_done    <= 1'b0;
            r_mat_rsp_valid <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_mat_rsp_valid <= w_mat_ready;
            r_clear_done    <= (r_state == CLEAR) && (r_clr_cnt == LAST_ADDR);
            r_clr_cnt       <= (r_state == CLEAR) ? r_clr_cnt + 1'b1 : '0;

            if (w_upd_ready) begin
                r_upd_addr  <= i_upd_addr;
                r_upd_delta <= i_upd_delta;
            end

            if (w_mat_ready || !i_mat_valid) begin
                r_starve_cnt <= '0;
            end else if (w_upd_ready) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

`ifdef OCC_ARB_DUMP_PORT_EN
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_dump_rsp_valid <= 1'b0;
        end else begin
            r_dump_rsp_valid <= w_dump_ready;
        end
    end

    assign o_dump_ready     = w_dump_ready;
    assign o_dump_rsp_valid = r_dump_rsp_valid && i_reset;
    assign o_dump_rsp_data  = o_dump_rsp_valid ? i_mem_rdata : '0;
`endif

    assign o_upd_ready     = w_upd_ready;
    assign o_mat_ready     = w_mat_ready;
    assign o_mat_rsp_valid = r_mat_rsp_valid && i_reset;
    assign o_mat_rsp_data  = o_mat_rsp_valid ? i_mem_rdata : '0;
    assign o_clear_done    = r_clear_done && i_reset;
    assign o_busy          = i_reset && (r_state != IDLE);
    assign o_mem_addr      = w_mem_addr;
    assign o_mem_we        = w_mem_we;
    assign o_mem_wdata     = w_mem_wdata;

endmodule

// File: tb/tb_occupancy_map_arbiter.sv
// ---------------------------------------------------------------------------
// tb_occupancy_map_arbiter
// Directed bench for occupancy_map_arbiter with a behavioural single-port
// RAM (registered read data, one cycle after the address).
// ---------------------------------------------------------------------------
module tb_occupancy_map_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear_start = 1'b0;
    logic        clear_done;
    logic        busy;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [14:0] upd_addr = '0;
    logic [7:0]  upd_delta = '0;
    logic        mat_valid = 1'b0;
    logic        mat_ready;
    logic [14:0] mat_addr = '0;
    logic        mat_rsp_valid;
    logic [7:0]  mat_rsp_data;
`ifdef OCC_ARB_DUMP_PORT_EN
    logic        dump_valid = 1'b0;
    logic        dump_ready;
    logic [14:0] dump_addr = '0;
    logic        dump_rsp_valid;
    logic [7:0]  dump_rsp_data;
`endif
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  ram [0:32767];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    occupancy_map_arbiter dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_clear_start   (clear_start),
        .o_clear_done    (clear_done),
        .o_busy          (busy),
        .i_upd_valid     (upd_valid),
        .o_upd_ready     (upd_ready),
        .i_upd_addr      (upd_addr),
        .i_upd_delta     (upd_delta),
        .i_mat_valid     (mat_valid),
        .o_mat_ready     (mat_ready),
        .i_mat_addr      (mat_addr),
        .o_mat_rsp_valid (mat_rsp_valid),
        .o_mat_rsp_data  (mat_rsp_data),
`ifdef OCC_ARB_DUMP_PORT_EN
        .i_dump_valid    (dump_valid),
        .o_dump_ready    (dump_ready),
        .i_dump_addr     (dump_addr),
        .o_dump_rsp_valid(dump_rsp_valid),
        .o_dump_rsp_data (dump_rsp_data),
`endif
        .o_mem_addr      (mem_addr),
        .o_mem_we        (mem_we),
        .o_mem_wdata     (mem_wdata),
        .i_mem_rdata     (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad_ready;
        int bad_wr;
        int done_cnt;
        int nonzero;
        int late_writes;
        logic eu;
        logic em;

        for (int a = 0; a < 32768; a++) ram[a] = 8'h00;

        // ---- Reset: outputs quiet even with requests present ----
        upd_valid   = 1'b1;
        mat_valid   = 1'b1;
        clear_start = 1'b1;
        tick();
        tick();
        check("rst_upd_ready", upd_ready, 0);
        check("rst_mat_ready", mat_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_rsp_valid", mat_rsp_valid, 0);
        check("rst_rsp_data", mat_rsp_data, 0);
        upd_valid   = 1'b0;
        mat_valid   = 1'b0;
        clear_start = 1'b0;
        rst         = 1'b1;
        tick();

        // ---- Update 100 + 50 at 0x0105 saturates to 127 ----
        ram[15'h0105] = 8'd100;
        upd_valid = 1'b1;
        upd_addr  = 15'h0105;
        upd_delta = 8'd50;
        #1;
        check("upd1_ready", upd_ready, 1);
        check("upd1_rd_addr", mem_addr, 15'h0105);
        check("upd1_rd_we", mem_we, 0);
        tick();
        upd_valid = 1'b0;
        mat_valid = 1'b1;
        mat_addr  = 15'h0105;
        #1;
        check("upd1_wr_we", mem_we, 1);
        check("upd1_wr_addr", mem_addr, 15'h0105);
        check("upd1_wr_data", mem_wdata, 8'h7F);
        check("upd1_busy", busy, 1);
        check("upd1_no_grant_mat", mat_ready, 0);
        tick();
        check("rd_after_wr_ready", mat_ready, 1);
        check("rd_after_wr_addr", mem_addr, 15'h0105);
        tick();
        mat_valid = 1'b0;
        #1;
        check("rd_after_wr_valid", mat_rsp_valid, 1);
        check("rd_after_wr_data", mat_rsp_data, 8'h7F);

        // ---- Update -120 + -20 saturates to -127 ----
        ram[15'h0200] = 8'h88;
        upd_valid = 1'b1;
        upd_addr  = 15'h0200;
        upd_delta = 8'hEC;
        #1;
        check("upd2_ready", upd_ready, 1);
        tick();
        upd_valid = 1'b0;
        #1;
        check("upd2_wr_data", mem_wdata, 8'h81);
        check("upd2_wr_addr", mem_addr, 15'h0200);
        tick();

        // ---- Update 5 + -3 = 2 (no saturation) ----
        ram[15'h0010] = 8'h05;
        upd_valid = 1'b1;
        upd_addr  = 15'h0010;
        upd_delta = 8'hFD;
        tick();
        upd_valid = 1'b0;
        #1;
        check("upd3_wr_data", mem_wdata, 8'h02);
        tick();

        // ---- Three back-to-back matcher reads ----
        ram[0] = 8'h0B;
        ram[1] = 8'h16;
        ram[2] = 8'h21;
        mat_valid = 1'b1;
        mat_addr  = 15'd0;
        #1;
        check("b2b_ready0", mat_ready, 1);
        tick();
        mat_addr = 15'd1;
        #1;
        check("b2b_ready1", mat_ready, 1);
        check("b2b_rsp0_valid", mat_rsp_valid, 1);
        check("b2b_rsp0_data", mat_rsp_data, 8'h0B);
        tick();
        mat_addr = 15'd2;
        #1;
        check("b2b_rsp1_valid", mat_rsp_valid, 1);
        check("b2b_rsp1_data", mat_rsp_data, 8'h16);
        tick();
        mat_valid = 1'b0;
        #1;
        check("b2b_rsp2_valid", mat_rsp_valid, 1);
        check("b2b_rsp2_data", mat_rsp_data, 8'h21);
        tick();
        check("b2b_rsp_end", mat_rsp_valid, 0);

        // ---- Starvation: 4 update grants then 1 matcher grant ----
        upd_valid = 1'b1;
        upd_addr  = 15'h0300;
        upd_delta = 8'h00;
        mat_valid = 1'b1;
        mat_addr  = 15'h0301;
        #1;
        for (int k = 0; k < 18; k++) begin
            eu = (k == 0 || k == 2 || k == 4 || k == 6 || k == 9 || k == 11 || k == 13 || k == 15);
            em = (k == 8 || k == 17);
            check($sformatf("starve_upd_c%0d", k), upd_ready, eu);
            check($sformatf("starve_mat_c%0d", k), mat_ready, em);
            tick();
        end
        upd_valid = 1'b0;
        mat_valid = 1'b0;
        tick();
        tick();

        // ---- Clear with a concurrent update request ----
        ram[15'h7FFF] = 8'h44;
        clear_start = 1'b1;
        upd_valid   = 1'b1;
        upd_addr    = 15'h0105;
        upd_delta   = 8'h01;
        #1;
        check("clr_start_upd_ready", upd_ready, 0);
        check("clr_start_we", mem_we, 0);
        tick();
        clear_start = 1'b0;
        bad_ready = 0;
        bad_wr    = 0;
        done_cnt  = 0;
        for (int i = 0; i < 32768; i++) begin
            if (upd_ready) bad_ready++;
            if (!mem_we || mem_addr != 15'(i) || mem_wdata != 8'h00 || !busy) bad_wr++;
            if (clear_done) done_cnt++;
            tick();
        end
        upd_valid = 1'b0;
        #1;
        if (clear_done) done_cnt++;
        check("clr_done_pulse", clear_done, 1);
        check("clr_busy_after", busy, 0);
        check("clr_upd_ready_blocked", bad_ready, 0);
        check("clr_write_sweep", bad_wr, 0);
        tick();
        if (clear_done) done_cnt++;
        check("clr_done_low", clear_done, 0);
        check("clr_done_once", done_cnt, 1);
        nonzero = 0;
        for (int a = 0; a < 32768; a++) if (ram[a] != 8'h00) nonzero++;
        check("clr_all_zero", nonzero, 0);
        mat_valid = 1'b1;
        mat_addr  = 15'h7FFF;
        tick();
        mat_valid = 1'b0;
        #1;
        check("clr_read_last_valid", mat_rsp_valid, 1);
        check("clr_read_last_data", mat_rsp_data, 8'h00);
        tick();

        // ---- Reset at write 1000 of a clear ----
        ram[999]  = 8'h05;
        ram[1001] = 8'h09;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (clear_done) done_cnt++;
            tick();
        end
        check("abort_at_1000", mem_addr, 15'd1000);
        rst = 1'b0;
        tick();
        check("abort_we", mem_we, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_busy", busy, 0);
        check("abort_done", clear_done, 0);
        rst = 1'b1;
        late_writes = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (mem_we) late_writes++;
            if (clear_done) done_cnt++;
            tick();
        end
        check("abort_no_writes", late_writes, 0);
        check("abort_no_done", done_cnt, 0);
        check("abort_ram_999", ram[999], 8'h00);
        check("abort_ram_1001", ram[1001], 8'h09);
        upd_valid = 1'b1;
        upd_addr  = 15'h0105;
        upd_delta = 8'h01;
        #1;
        check("abort_idle_grant", upd_ready, 1);
        tick();
        upd_valid = 1'b0;
        #1;
        check("abort_upd_wdata", mem_wdata, 8'h01);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
